// File: rtl/dpbram_access_sched_pkg.sv
// Shared state encoding and read-burst layout for the Zynq-side DPBRAM
// access scheduler.
package dpbram_access_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ      = 2'd2,
    ST_READ_LAST = 2'd3
  } sched_state_e;

  typedef enum logic {
    CLS_WRITE = 1'b0,
    CLS_READ  = 1'b1
  } traffic_class_e;

  localparam int unsigned RD_BURST_LEN = 4;

  localparam logic [1:0] RD_OFS_STATUS = 2'd0;
  localparam logic [1:0] RD_OFS_VER    = 2'd1;
  localparam logic [1:0] RD_OFS_CNT_LO = 2'd2;
  localparam logic [1:0] RD_OFS_CNT_HI = 2'd3;

endpackage

// File: rtl/dpbram_access_sched_poll_timer.sv
// Free-running poll interval counter; a period of zero parks the counter and
// suppresses ticks.
module dpbram_access_sched_poll_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_period,
  output logic        o_tick
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [31:0] last_cnt;

  // A period shortened below the running count wraps silently, so a live
  // period change never produces a spurious poll.
  always_comb begin
    cnt_d    = cnt_q;
    o_tick   = 1'b0;
    last_cnt = i_period - 32'd1;
    if (i_period == 32'd0) begin
      cnt_d = '0;
    end else if (cnt_q == last_cnt) begin
      cnt_d  = '0;
      o_tick = 1'b1;
    end else if (cnt_q > last_cnt) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dpbram_access_sched.sv
// Shares one DPBRAM port between the parameter-block write burst and the
// periodic DSP status/version/counter read burst.
module dpbram_access_sched
  import dpbram_access_sched_pkg::*;
#(
  parameter int unsigned                 C_ADDR_WIDTH = 10,
  parameter int unsigned                 C_WR_WORDS   = 40,
  parameter logic [C_ADDR_WIDTH-1:0]     C_WR_BASE    = 10'h000,
  parameter logic [C_ADDR_WIDTH-1:0]     C_RD_BASE    = 10'h200
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic [C_WR_WORDS*16-1:0]    i_wr_data,
  input  logic                        i_wr_req,
  input  logic [31:0]                 i_rd_period,
  output logic                        o_bram_en,
  output logic                        o_bram_we,
  output logic [C_ADDR_WIDTH-1:0]     o_bram_addr,
  output logic [15:0]                 o_bram_din,
  input  logic [15:0]                 i_bram_dout,
  output logic [15:0]                 o_dsp_status,
  output logic [15:0]                 o_dsp_ver,
  output logic [31:0]                 o_wf_read_cnt,
  output logic                        o_busy,
  output logic                        o_wr_done,
  output logic                        o_rd_done
);

  localparam logic [7:0] WR_LAST_IDX = 8'(C_WR_WORDS - 1);
  localparam logic [1:0] RD_LAST_IDX = 2'(RD_BURST_LEN - 1);

  sched_state_e             state_q, state_d;
  traffic_class_e           last_tie_q, last_tie_d;
  logic                     wr_pend_q, wr_pend_d;
  logic                     rd_pend_q, rd_pend_d;
  logic [7:0]               idx_q, idx_d;
  logic [C_WR_WORDS*16-1:0] shadow_q, shadow_d;
  logic [2:0][15:0]         stage_q, stage_d;
  logic [15:0]              dsp_status_q, dsp_status_d;
  logic [15:0]              dsp_ver_q, dsp_ver_d;
  logic [31:0]              wf_cnt_q, wf_cnt_d;
  logic                     wr_done_q, wr_done_d;
  logic                     rd_done_q, rd_done_d;
  logic                     poll_tick;
  logic                     start_wr;
  logic                     start_rd;

  dpbram_access_sched_poll_timer u_poll_timer (
    .clk      (S_AXI_ACLK),
    .rst_n    (S_AXI_ARESETN),
    .i_period (i_rd_period),
    .o_tick   (poll_tick)
  );

  // last_tie only moves when both classes contend, so a lone burst of either
  // class does not disturb the alternation between contested starts.
  always_comb begin
    state_d      = state_q;
    last_tie_d   = last_tie_q;
    wr_pend_d    = wr_pend_q | i_wr_req;
    rd_pend_d    = rd_pend_q | poll_tick;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    stage_d      = stage_q;
    dsp_status_d = dsp_status_q;
    dsp_ver_d    = dsp_ver_q;
    wf_cnt_d     = wf_cnt_q;
    wr_done_d    = 1'b0;
    rd_done_d    = 1'b0;
    start_wr     = 1'b0;
    start_rd     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (wr_pend_q && rd_pend_q) begin
          if (last_tie_q == CLS_WRITE) begin
            start_rd   = 1'b1;
            last_tie_d = CLS_READ;
          end else begin
            start_wr   = 1'b1;
            last_tie_d = CLS_WRITE;
          end
        end else if (wr_pend_q) begin
          start_wr = 1'b1;
        end else if (rd_pend_q) begin
          start_rd = 1'b1;
        end

        if (start_wr) begin
          state_d   = ST_WRITE;
          idx_d     = '0;
          shadow_d  = i_wr_data;
          wr_pend_d = i_wr_req;
        end else if (start_rd) begin
          state_d   = ST_READ;
          idx_d     = '0;
          rd_pend_d = poll_tick;
        end
      end

      ST_WRITE: begin
        shadow_d = shadow_q >> 16;
        idx_d    = idx_q + 8'd1;
        if (idx_q == WR_LAST_IDX) begin
          state_d   = ST_IDLE;
          wr_done_d = 1'b1;
        end
      end

      // Read data lags its address by one clock, so the word landing now
      // belongs to the previous issue slot.
      ST_READ: begin
        unique case (idx_q[1:0])
          2'd1:    stage_d[0] = i_bram_dout;
          2'd2:    stage_d[1] = i_bram_dout;
          2'd3:    stage_d[2] = i_bram_dout;
          default: ;
        endcase
        idx_d = idx_q + 8'd1;
        if (idx_q[1:0] == RD_LAST_IDX) begin
          state_d = ST_READ_LAST;
        end
      end

      ST_READ_LAST: begin
        dsp_status_d = stage_q[RD_OFS_STATUS];
        dsp_ver_d    = stage_q[RD_OFS_VER];
        wf_cnt_d     = {i_bram_dout, stage_q[RD_OFS_CNT_LO]};
        rd_done_d    = 1'b1;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      last_tie_q   <= CLS_WRITE;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      idx_q        <= '0;
      shadow_q     <= '0;
      stage_q      <= '0;
      dsp_status_q <= '0;
      dsp_ver_q    <= '0;
      wf_cnt_q     <= '0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_tie_q   <= last_tie_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      stage_q      <= stage_d;
      dsp_status_q <= dsp_status_d;
      dsp_ver_q    <= dsp_ver_d;
      wf_cnt_q     <= wf_cnt_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
    end
  end

  // Port strobes decode straight from the state register so a reset drops
  // them without waiting for a clock.
  always_comb begin
    o_bram_en   = 1'b0;
    o_bram_we   = 1'b0;
    o_bram_addr = '0;
    o_bram_din  = '0;
    unique case (state_q)
      ST_WRITE: begin
        o_bram_en   = 1'b1;
        o_bram_we   = 1'b1;
        o_bram_addr = C_WR_BASE + C_ADDR_WIDTH'(idx_q);
        o_bram_din  = shadow_q[15:0];
      end
      ST_READ: begin
        o_bram_en   = 1'b1;
        o_bram_addr = C_RD_BASE + C_ADDR_WIDTH'(idx_q);
      end
      default: ;
    endcase
  end

  assign o_busy        = (state_q != ST_IDLE);
  assign o_dsp_status  = dsp_status_q;
  assign o_dsp_ver     = dsp_ver_q;
  assign o_wf_read_cnt = wf_cnt_q;
  assign o_wr_done     = wr_done_q;
  assign o_rd_done     = rd_done_q;

endmodule

// File: tb/tb_dpbram_access_sched.sv
// Randomized bench for dpbram_access_sched against a transaction-schedule
// reference model of the shared BRAM port.
module tb_dpbram_access_sched;

  localparam int         NW      = 40;
  localparam logic [9:0] WR_BASE = 10'h000;
  localparam logic [9:0] RD_BASE = 10'h200;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NW*16-1:0]  wr_data;
  logic              wr_req;
  logic [31:0]       rd_period;
  logic              bram_en, bram_we;
  logic [9:0]        bram_addr;
  logic [15:0]       bram_din;
  logic [15:0]       bram_dout = '0;
  logic [15:0]       dsp_status, dsp_ver;
  logic [31:0]       wf_cnt;
  logic              busy, wr_done, rd_done;

  always #5 clk = ~clk;

  dpbram_access_sched dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .i_wr_data     (wr_data),
    .i_wr_req      (wr_req),
    .i_rd_period   (rd_period),
    .o_bram_en     (bram_en),
    .o_bram_we     (bram_we),
    .o_bram_addr   (bram_addr),
    .o_bram_din    (bram_din),
    .i_bram_dout   (bram_dout),
    .o_dsp_status  (dsp_status),
    .o_dsp_ver     (dsp_ver),
    .o_wf_read_cnt (wf_cnt),
    .o_busy        (busy),
    .o_wr_done     (wr_done),
    .o_rd_done     (rd_done)
  );

  // BRAM model: the DSP-owned read window is served from rd_region.
  logic [15:0] mem [1024];
  logic [15:0] rd_region [4];
  int          nwrites = 0;

  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) begin
        mem[bram_addr] <= bram_din;
        nwrites <= nwrites + 1;
      end
      if (bram_addr[9:2] == RD_BASE[9:2]) bram_dout <= rd_region[bram_addr[1:0]];
      else bram_dout <= mem[bram_addr];
    end
  end

  typedef struct {
    logic       en;
    logic       we;
    logic [9:0] addr;
    logic [15:0] din;
  } op_t;

  op_t         exp_q[$];
  logic        m_wr_pend, m_rd_pend;
  int          m_last_tie;
  logic [31:0] m_tcnt;
  longint      m_cyc = 0;
  longint      m_wr_done_at, m_rd_done_at;
  logic [15:0] m_status, m_ver;
  logic [31:0] m_cnt;
  logic [15:0] m_rd_next [4];

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expv, m_cyc);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    m_wr_pend    = 1'b0;
    m_rd_pend    = 1'b0;
    m_last_tie   = 0;
    m_tcnt       = '0;
    m_wr_done_at = -1;
    m_rd_done_at = -1;
    m_status     = '0;
    m_ver        = '0;
    m_cnt        = '0;
  endtask

  // One clock: check this cycle against the schedule, drive inputs, advance.
  task automatic applyStimulus(input logic req);
    op_t  cur;
    logic idle;
    logic tick;
    logic started_wr;
    logic started_rd;
    if (m_cyc == m_rd_done_at) begin
      m_status = m_rd_next[0];
      m_ver    = m_rd_next[1];
      m_cnt    = {m_rd_next[3], m_rd_next[2]};
    end
    idle = (exp_q.size() == 0);
    if (idle) cur = '{en: 1'b0, we: 1'b0, addr: '0, din: '0};
    else cur = exp_q[0];
    checkOutput("bram_en", bram_en, cur.en);
    checkOutput("bram_we", bram_we, cur.we);
    if (cur.en) checkOutput("bram_addr", bram_addr, cur.addr);
    if (cur.we) checkOutput("bram_din", bram_din, cur.din);
    checkOutput("busy", busy, !idle);
    checkOutput("wr_done", wr_done, m_cyc == m_wr_done_at);
    checkOutput("rd_done", rd_done, m_cyc == m_rd_done_at);
    checkOutput("dsp_status", dsp_status, m_status);
    checkOutput("dsp_ver", dsp_ver, m_ver);
    checkOutput("wf_read_cnt", wf_cnt, m_cnt);

    wr_req = req;

    tick = 1'b0;
    if (rd_period == 0) m_tcnt = 0;
    else if (m_tcnt + 1 == rd_period) begin tick = 1'b1; m_tcnt = 0; end
    else if (m_tcnt >= rd_period) m_tcnt = 0;
    else m_tcnt = m_tcnt + 1;

    started_wr = 1'b0;
    started_rd = 1'b0;
    if (idle) begin
      if (m_wr_pend && m_rd_pend) begin
        if (m_last_tie == 0) started_rd = 1'b1; else started_wr = 1'b1;
        m_last_tie = started_rd ? 1 : 0;
      end else begin
        started_wr = m_wr_pend;
        started_rd = m_rd_pend;
      end
      if (started_wr) begin
        for (int k = 0; k < NW; k++)
          exp_q.push_back('{en: 1'b1, we: 1'b1, addr: WR_BASE + 10'(k), din: wr_data[16*k +: 16]});
        m_wr_done_at = m_cyc + NW + 1;
      end
      if (started_rd) begin
        for (int k = 0; k < 4; k++) begin
          exp_q.push_back('{en: 1'b1, we: 1'b0, addr: RD_BASE + 10'(k), din: '0});
          m_rd_next[k] = rd_region[k];
        end
        exp_q.push_back('{en: 1'b0, we: 1'b0, addr: '0, din: '0});
        m_rd_done_at = m_cyc + 6;
      end
    end else begin
      void'(exp_q.pop_front());
    end
    m_wr_pend = (m_wr_pend && !started_wr) || req;
    m_rd_pend = (m_rd_pend && !started_rd) || tick;
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0);
  endtask

  task automatic doReset();
    rst_n  = 1'b0;
    wr_req = 1'b0;
    #1;
    checkOutput("rst_en", bram_en, 0);
    checkOutput("rst_we", bram_we, 0);
    checkOutput("rst_addr", bram_addr, 0);
    checkOutput("rst_din", bram_din, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_wr_done", wr_done, 0);
    checkOutput("rst_rd_done", rd_done, 0);
    checkOutput("rst_status", dsp_status, 0);
    checkOutput("rst_ver", dsp_ver, 0);
    checkOutput("rst_cnt", wf_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  task automatic randomWrData();
    for (int i = 0; i < NW / 2; i++) wr_data[32*i +: 32] = $urandom;
  endtask

  // Waits (bounded) for a quiet idle cycle whose timer is one short of a poll.
  task automatic alignTie(input logic [31:0] per);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_tcnt == per - 1 && exp_q.size() == 0 && !m_wr_pend && !m_rd_pend) found = 1'b1;
      else applyStimulus(1'b0);
    end
    checkOutput("tie_align", found, 1);
    applyStimulus(1'b1);
  endtask

  initial begin
    logic found;
    wr_req    = 1'b0;
    wr_data   = '0;
    rd_period = '0;
    for (int k = 0; k < 4; k++) rd_region[k] = '0;
    modelReset();
    @(negedge clk);
    doReset();

    // Single write burst with a recognisable pattern.
    for (int k = 0; k < NW; k++) wr_data[16*k +: 16] = 16'hA000 + 16'(k);
    applyStimulus(1'b1);
    runCycles(60);
    checkOutput("write_count", nwrites, NW);
    checkOutput("mem_first", mem[WR_BASE], 16'hA000);
    checkOutput("mem_mid", mem[WR_BASE + 10'd17], 16'hA011);
    checkOutput("mem_last", mem[WR_BASE + 10'd39], 16'hA027);

    // Periodic poll of fixed DSP values.
    rd_region[0] = 16'h1234;
    rd_region[1] = 16'h0102;
    rd_region[2] = 16'hBEEF;
    rd_region[3] = 16'h0001;
    rd_period = 32'd100;
    runCycles(350);
    checkOutput("poll_status", dsp_status, 16'h1234);
    checkOutput("poll_cnt", wf_cnt, 32'h0001BEEF);

    // Write request and poll tick in the same cycle, twice.
    @(negedge clk);
    doReset();
    rd_period = 32'd60;
    randomWrData();
    alignTie(32'd60);
    runCycles(2);
    checkOutput("tie1_read_first", bram_we, 0);
    runCycles(60);
    randomWrData();
    alignTie(32'd60);
    runCycles(2);
    checkOutput("tie2_write_first", bram_we, 1);
    runCycles(60);

    // Coalesced requests and data changing under an active burst.
    rd_period = 32'd0;
    runCycles(60);
    randomWrData();
    applyStimulus(1'b1);
    for (int i = 0; i < 45; i++) begin
      if (i == 10 || i == 30) randomWrData();
      applyStimulus(i == 5 || i == 15 || i == 25);
    end
    runCycles(60);

    // Reset in the middle of a write burst.
    randomWrData();
    applyStimulus(1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (exp_q.size() > 0 && exp_q[0].we && exp_q[0].addr == WR_BASE + 10'd17) found = 1'b1;
      else applyStimulus(1'b0);
    end
    checkOutput("reach_word17", found, 1);
    checkOutput("pre_rst_we", bram_we, 1);
    doReset();
    runCycles(100);

    // Polling disabled, then a shortened period while the timer is mid-count.
    rd_period = 32'd0;
    runCycles(1000);
    rd_period = 32'd50;
    runCycles(23);
    rd_period = 32'd5;
    runCycles(60);

    // Random traffic mix.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) randomWrData();
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 4) == 0) rd_period = 32'd0;
        else rd_period = 32'($urandom_range(1, 40));
      end
      if (exp_q.size() == 0 && $urandom_range(0, 9) == 0)
        for (int k = 0; k < 4; k++) rd_region[k] = 16'($urandom);
      applyStimulus($urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dpbram_access_sched.md
# dpbram_access_sched

Access scheduler for the Zynq-side port of the dual-port BRAM shared with the DSP. It writes the Zynq parameter block (status, version, set points, gains, limits, deadband, switching frequency) into the DPBRAM as a burst on request, and periodically polls the DSP status, version and waveform read counter back out. The two traffic classes share a single BRAM port. The block sits between the AXI4-Lite register file outputs and the DPBRAM, in the S_AXI_ACLK domain.

## Interface
Parameters:
- C_ADDR_WIDTH, 10, BRAM word address width
- C_WR_WORDS, 40, number of 16-bit words in the write burst (2..256)
- C_WR_BASE, 10'h000, BRAM address of write word 0
- C_RD_BASE, 10'h200, BRAM address of read word 0 (read burst is fixed at 4 words)

Ports:
- S_AXI_ACLK, in, 1, clock
- S_AXI_ARESETN, in, 1, asynchronous active-low reset
- i_wr_data, in, C_WR_WORDS*16, parameter block; word k is bits [16k +: 16]
- i_wr_req, in, 1, single-cycle write-burst request
- i_rd_period, in, 32, poll interval in clocks; 0 disables polling
- o_bram_en, out, 1, BRAM port enable
- o_bram_we, out, 1, BRAM write enable
- o_bram_addr, out, C_ADDR_WIDTH, BRAM address
- o_bram_din, out, 16, BRAM write data
- i_bram_dout, in, 16, BRAM read data, valid 1 clock after the address
- o_dsp_status, out, 16, read word 0
- o_dsp_ver, out, 16, read word 1
- o_wf_read_cnt, out, 32, {read word 3, read word 2}
- o_busy, out, 1, high while a burst is in progress
- o_wr_done, out, 1, pulse when a write burst completes
- o_rd_done, out, 1, pulse when the read outputs update

## Operation
- States: IDLE, WRITE, READ, READ_LAST.
- Poll timer:
  - Counts up in every state.
  - When it reaches i_rd_period-1 it sets rd_pend and wraps to 0.
  - If i_rd_period is 0, the timer is held at 0 and no poll is raised.
  - If i_rd_period is reduced below the current count, the timer wraps to 0 without raising a poll.
- Write requests: i_wr_req sets wr_pend in any state.
  - Multiple requests during a burst coalesce into one pending burst.
- Arbitration in IDLE:
  - Only one class pending: start that class.
  - Both pending: start the class opposite to last_served.
  - last_served resets to WRITE, so reads win the first tie.
  - Starting a burst clears that class's pend flag in the same cycle.
- WRITE:
  - i_wr_data is snapshotted into a shadow register on entry, so the burst is internally consistent.
  - Word k goes to C_WR_BASE+k with en=we=1, one word per clock, k = 0..C_WR_WORDS-1.
  - After the last word the FSM returns to IDLE and o_wr_done pulses.
- READ:
  - Addresses C_RD_BASE+0..3 are issued on 4 consecutive clocks with en=1, we=0.
  - Data is captured into staging registers one clock after each address.
  - READ_LAST captures word 3. In the following cycle all read outputs update together and o_rd_done pulses. Outputs never show a mixed old/new set.
- Bursts are never preempted. A pending request waits in IDLE for one cycle minimum.
- Address arithmetic wraps modulo 2^C_ADDR_WIDTH.

## Timing
- Reset: every output is 0; FSM in IDLE; pend flags, timer and last_served are cleared.
- Reset asserted mid-burst: en and we drop asynchronously. The partial burst is abandoned and not resumed.
- Write request to first BRAM write: i_wr_req at cycle t gives first write at t+2 (t+1 pend registered/arbitrated, t+2 WRITE word 0).
- Write burst: C_WR_WORDS cycles of we=1. o_wr_done pulses in the cycle after the last write.
- Poll flag to output update: the read burst occupies 4 issue clocks plus the READ_LAST clock. Outputs and o_rd_done update 6 clocks after the IDLE arbitration cycle.
- o_busy is high in every non-IDLE state.
- o_bram_en is low in IDLE; o_bram_we is high only in WRITE.

## Structure
- A shared package holds:
  - the state encoding (IDLE, WRITE, READ, READ_LAST);
  - read word offsets (STATUS=0, VER=1, CNT_LO=2, CNT_HI=3);
  - the read burst length constant 4.
- One sub-module, poll_timer: period counter with the zero-disable and wrap rules above; outputs a tick.

## Test plan
- Reset, then i_wr_req with C_WR_WORDS=40 and word k = 16'hA000+k -> 40 writes at 0x000..0x027 with matching data, o_wr_done pulse, no other writes.
- i_rd_period=100, BRAM model 0x200..0x203 = 1234, 0102, BEEF, 0001 -> every 100 clocks o_dsp_status=16'h1234, o_dsp_ver=16'h0102, o_wf_read_cnt=32'h0001BEEF, updated atomically with o_rd_done.
- i_wr_req and a poll tick in the same cycle after reset -> read burst first, then write burst; repeat the tie -> write first.
- Three i_wr_req pulses during one write burst, i_wr_data changed mid-burst -> first burst carries the snapshot data, exactly one further burst follows.
- S_AXI_ARESETN low at write word 17 -> en/we drop immediately, all outputs 0; after release there is no write until a new i_wr_req.
- i_rd_period=0 for 1000 clocks -> no reads. i_rd_period set to 5 with the timer mid-count -> polls every 5 clocks with no spurious tick at the change.
